// File: rtl/ws2812_pkg.sv
// Shared types and helpers for the WS2812 chain driver: FSM states, colour width,
// time-to-cycle conversion and per-channel brightness scaling.
package ws2812_pkg;

    localparam int unsigned GRB_W = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HIGH,
        S_LOW,
        S_LATCH
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_HIGH,
        PH_LOW
    } phase_t;

    // floor(clk_hz * t / units_per_s); units_per_s is 1e9 for ns, 1e6 for us.
    function automatic int unsigned time_to_cycles(input longint unsigned clk_hz,
                                                   input longint unsigned t,
                                                   input longint unsigned units_per_s);
        return 32'((clk_hz * t) / units_per_s);
    endfunction

    function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b);
        logic [16:0] p;
        p = {9'd0, c} * ({9'd0, b} + 17'd1);
        return 8'(p >> 8);
    endfunction

    function automatic logic [GRB_W-1:0] scale_grb(input logic [GRB_W-1:0] w,
                                                   input logic [7:0] b);
        return {scale_chan(w[23:16], b), scale_chan(w[15:8], b), scale_chan(w[7:0], b)};
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Single-bit WS2812 waveform generator: a HIGH phase then a LOW phase whose lengths
// depend on the bit value. A new bit can be accepted on the last LOW cycle, so bits abut.
module ws2812_bit_encoder
    import ws2812_pkg::*;
#(
    parameter int unsigned H0 = 20,
    parameter int unsigned L0 = 42,
    parameter int unsigned H1 = 40,
    parameter int unsigned L1 = 22
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic tx_bit,
    output logic line,
    output logic high_end,
    output logic pre_done,
    output logic bit_done
);

    localparam int unsigned HMAX = (H0 > H1) ? H0 : H1;
    localparam int unsigned LMAX = (L0 > L1) ? L0 : L1;
    localparam int unsigned TMAX = (HMAX > LMAX) ? HMAX : LMAX;
    localparam int unsigned CW   = (TMAX > 3) ? $clog2(TMAX + 1) : 2;

    phase_t          phase;
    logic [CW-1:0]   cnt;
    logic            sel;
    logic [CW-1:0]   h_len;
    logic [CW-1:0]   l_len;
    logic            accept;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        h_len    = sel ? CW'(H1) : CW'(H0);
        l_len    = sel ? CW'(L1) : CW'(L0);
        high_end = (phase == PH_HIGH) && (cnt == h_len - 1'b1);
        bit_done = (phase == PH_LOW) && (cnt == l_len - 1'b1);
        // One cycle ahead of bit_done; LOW phases must therefore be at least 2 cycles.
        pre_done = (phase == PH_LOW) && (cnt == l_len - 2'd2);
        accept   = valid && ((phase == PH_IDLE) || bit_done);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= PH_IDLE;
            cnt   <= '0;
            sel   <= 1'b0;
            line  <= 1'b0;
        end else if (accept) begin
            phase <= PH_HIGH;
            cnt   <= '0;
            sel   <= tx_bit;
            line  <= 1'b1;
        end else begin
            unique case (phase)
                PH_HIGH: begin
                    if (high_end) begin
                        phase <= PH_LOW;
                        cnt   <= '0;
                        line  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PH_LOW: begin
                    if (bit_done) begin
                        phase <= PH_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ws2812_chain_driver.sv
// WS2812 chain driver: frame buffer, brightness scaling and LED/bit sequencing on top of
// the bit encoder, followed by the latch low period and a one-cycle done pulse.
module ws2812_chain_driver
    import ws2812_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned NUM_LEDS    = 8,
    parameter int unsigned T0H_NS      = 400,
    parameter int unsigned T0L_NS      = 850,
    parameter int unsigned T1H_NS      = 800,
    parameter int unsigned T1L_NS      = 450,
    parameter int unsigned RESET_US    = 60,
    localparam int unsigned AW         = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [GRB_W-1:0]  wr_data,
    input  logic [7:0]        brightness,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              data_out
);

    localparam longint unsigned NS_PER_S = 64'd1_000_000_000;
    localparam longint unsigned US_PER_S = 64'd1_000_000;

    localparam int unsigned N_T0H = time_to_cycles(64'(CLK_FREQ_HZ), 64'(T0H_NS), NS_PER_S);
    localparam int unsigned N_T0L = time_to_cycles(64'(CLK_FREQ_HZ), 64'(T0L_NS), NS_PER_S);
    localparam int unsigned N_T1H = time_to_cycles(64'(CLK_FREQ_HZ), 64'(T1H_NS), NS_PER_S);
    localparam int unsigned N_T1L = time_to_cycles(64'(CLK_FREQ_HZ), 64'(T1L_NS), NS_PER_S);
    localparam int unsigned N_RST = time_to_cycles(64'(CLK_FREQ_HZ), 64'(RESET_US), US_PER_S);
    localparam int unsigned RST_W = $clog2(N_RST + 1);

    localparam logic [4:0]       LAST_BIT = 5'(GRB_W - 1);
    localparam logic [AW-1:0]    LAST_LED = AW'(NUM_LEDS - 1);
    localparam logic [RST_W-1:0] LAT_LAST = RST_W'(N_RST - 1);

    logic [GRB_W-1:0] buf_mem [NUM_LEDS];

    state_t           state;
    logic [AW-1:0]    led_idx;
    logic [4:0]       bit_idx;
    logic [GRB_W-2:0] rest_bits;   // word in flight, MSB already handed to the encoder
    logic [RST_W-1:0] lat_cnt;
    logic [7:0]       bright_q;

    logic [GRB_W-1:0] load_word;
    logic             enc_valid;
    logic             enc_bit;
    logic             high_end;
    logic             pre_done;
    logic             bit_done;

    // NOTE: the frame buffer is reset explicitly; a blank chain after reset is part of the contract.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                buf_mem[i] <= '0;
            end
        end else if (wr_en && (32'(wr_addr) < NUM_LEDS)) begin
            buf_mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        load_word = scale_grb(buf_mem[led_idx], bright_q);
        enc_valid = 1'b0;
        enc_bit   = rest_bits[GRB_W-2];
        if (state == S_LOAD) begin
            enc_valid = 1'b1;
            enc_bit   = load_word[GRB_W-1];
        end else if ((state == S_LOW) && bit_done && (bit_idx != LAST_BIT)) begin
            enc_valid = 1'b1;
        end
    end

    // Between LEDs, LOAD is entered one cycle early so it coincides with the encoder's
    // last LOW cycle and the next word starts with no gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            led_idx   <= '0;
            bit_idx   <= '0;
            rest_bits <= '0;
            lat_cnt   <= '0;
            bright_q  <= 8'hFF;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        bright_q <= brightness;
                        led_idx  <= '0;
                        busy     <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    rest_bits <= load_word[GRB_W-2:0];
                    bit_idx   <= '0;
                    state     <= S_HIGH;
                end
                S_HIGH: begin
                    if (high_end) begin
                        state <= S_LOW;
                    end
                end
                S_LOW: begin
                    if ((bit_idx == LAST_BIT) && (led_idx != LAST_LED) && pre_done) begin
                        led_idx <= led_idx + 1'b1;
                        state   <= S_LOAD;
                    end else if (bit_done) begin
                        if (bit_idx == LAST_BIT) begin
                            lat_cnt <= '0;
                            state   <= S_LATCH;
                        end else begin
                            rest_bits <= rest_bits << 1;
                            bit_idx   <= bit_idx + 1'b1;
                            state     <= S_HIGH;
                        end
                    end
                end
                S_LATCH: begin
                    if (lat_cnt == LAT_LAST) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    ws2812_bit_encoder #(
        .H0 (N_T0H),
        .L0 (N_T0L),
        .H1 (N_T1H),
        .L1 (N_T1L)
    ) u_enc (
        .clk      (clk),
        .rst      (rst),
        .valid    (enc_valid),
        .tx_bit   (enc_bit),
        .line     (data_out),
        .high_end (high_end),
        .pre_done (pre_done),
        .bit_done (bit_done)
    );

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// Directed bench: an 8-LED chain at 50 MHz and a 1-LED chain at 100 MHz, decoding the
// serial line back into GRB words and checking every high/low run length.
module tb_ws2812_chain_driver;

    logic clk = 1'b0;
    logic rst;

    logic        wr_en0, start0, busy0, done0, d0_line;
    logic [2:0]  wr_addr0;
    logic [23:0] wr_data0;
    logic [7:0]  brightness0;

    logic        wr_en1, start1, busy1, done1, d1_line;
    logic [0:0]  wr_addr1;
    logic [23:0] wr_data1;
    logic [7:0]  brightness1;

    int n_vec = 0;
    int n_bad = 0;

    logic [191:0] bits_a, bits_b, bits_c, bits_p, bits_q;
    int bad_a, bad_b, bad_c, bad_p, bad_q;
    int lead_a, lead_b, lead_c, lead_p, lead_q;
    int seen_b, seen_r, hi_cnt;

    always #5 clk = ~clk;

    ws2812_chain_driver dut0 (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en0),
        .wr_addr    (wr_addr0),
        .wr_data    (wr_data0),
        .brightness (brightness0),
        .start      (start0),
        .busy       (busy0),
        .done       (done0),
        .data_out   (d0_line)
    );

    ws2812_chain_driver #(
        .CLK_FREQ_HZ (100_000_000),
        .NUM_LEDS    (1)
    ) dut1 (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en1),
        .wr_addr    (wr_addr1),
        .wr_data    (wr_data1),
        .brightness (brightness1),
        .start      (start1),
        .busy       (busy1),
        .done       (done1),
        .data_out   (d1_line)
    );

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic line_of(input int which);
        return (which != 0) ? d1_line : d0_line;
    endfunction

    function automatic logic done_of(input int which);
        return (which != 0) ? done1 : done0;
    endfunction

    task automatic write0(input logic [2:0] a, input logic [23:0] d);
        wr_en0 = 1'b1; wr_addr0 = a; wr_data0 = d;
        @(negedge clk);
        wr_en0 = 1'b0;
    endtask

    task automatic write1(input logic [0:0] a, input logic [23:0] d);
        wr_en1 = 1'b1; wr_addr1 = a; wr_data1 = d;
        @(negedge clk);
        wr_en1 = 1'b0;
    endtask

    task automatic pulse_start0();
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    // Decode one frame; returns the bits MSB-first in bits[nbits-1:0], a count of timing
    // errors, and how many cycles passed before the first rising edge.
    task automatic rx_frame(input int which, input int nbits,
                            input int t0h, input int t0l, input int t1h, input int t1l,
                            input int nrst,
                            output logic [191:0] bits, output int bad, output int lead);
        int h;
        int l;
        logic b;
        bits = '0;
        bad  = 0;
        lead = 0;
        while (!line_of(which) && lead < 20000) begin
            @(negedge clk);
            lead++;
        end
        if (!line_of(which)) begin
            bad = 1;
            return;
        end
        for (int i = 0; i < nbits; i++) begin
            h = 0;
            while (line_of(which) && h < 500) begin
                @(negedge clk);
                h++;
            end
            l = 0;
            while (!line_of(which) && !done_of(which) && l < 10000) begin
                @(negedge clk);
                l++;
            end
            b = (h == t1h);
            bits = {bits[190:0], b};
            if (h != (b ? t1h : t0h)) bad++;
            if (i == nbits - 1) begin
                if (!done_of(which) || l != (b ? t1l : t0l) + nrst) bad++;
            end else if (done_of(which) || l != (b ? t1l : t0l)) begin
                bad++;
            end
        end
    endtask

    task automatic wait_rises(input int which, input int n, output int seen);
        logic prev;
        int guard;
        seen  = 0;
        guard = 0;
        prev  = line_of(which);
        while (seen < n && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (line_of(which) && !prev) seen++;
            prev = line_of(which);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        wr_en0 = 1'b0; wr_addr0 = '0; wr_data0 = '0; brightness0 = 8'd255; start0 = 1'b0;
        wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0; brightness1 = 8'd0;   start1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data_out", 192'(d0_line), 192'd0);
        check("rst_busy", 192'(busy0), 192'd0);
        check("rst_done", 192'(done0), 192'd0);
        rst = 1'b1;
        @(negedge clk);

        // Frame A on the 8-LED chain, back-to-back frames on the 1-LED chain in parallel.
        write0(3'd0, 24'hFF0000);
        write1(1'b0, 24'h8001FF);
        write1(1'b1, 24'h123456);
        start0 = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        brightness1 = 8'd255;
        fork
            begin
                rx_frame(0, 192, 20, 42, 40, 22, 3000, bits_a, bad_a, lead_a);
                check("a_bits", bits_a, {24'hFF0000, 168'h0});
                check("a_timing", 192'(bad_a), 192'd0);
                @(negedge clk);
                check("a_done_width", 192'(done0), 192'd0);
                hi_cnt = 0;
                repeat (300) begin
                    @(negedge clk);
                    if (d0_line) hi_cnt++;
                end
                check("a_no_second_frame", 192'(hi_cnt), 192'd0);
                check("a_busy_after", 192'(busy0), 192'd0);
            end
            begin
                repeat (500) @(negedge clk);
                check("a_busy_mid", 192'(busy0), 192'd1);
                pulse_start0();
            end
            begin
                rx_frame(1, 24, 40, 85, 80, 45, 6000, bits_p, bad_p, lead_p);
                rx_frame(1, 24, 40, 85, 80, 45, 6000, bits_q, bad_q, lead_q);
                start1 = 1'b0;
                check("c1_f1_bits", bits_p, 192'h0);
                check("c1_f1_timing", 192'(bad_p), 192'd0);
                check("c1_f2_bits", bits_q, 192'h8001FF);
                check("c1_f2_timing", 192'(bad_q), 192'd0);
                check("c1_chain_gap", 192'(lead_q), 192'd2);
                repeat (3) @(negedge clk);
                check("c1_busy_after", 192'(busy1), 192'd0);
            end
        join

        // Frame B: half brightness plus writes while LED2 is on the wire.
        write0(3'd0, 24'h00FF00);
        write0(3'd1, 24'h102030);
        write0(3'd2, 24'h446688);
        write0(3'd6, 24'hFE0102);
        brightness0 = 8'd127;
        pulse_start0();
        fork
            rx_frame(0, 192, 20, 42, 40, 22, 3000, bits_b, bad_b, lead_b);
            begin
                wait_rises(0, 50, seen_b);
                write0(3'd2, 24'h000000);
                write0(3'd5, 24'hFFFFFF);
                brightness0 = 8'd0;
            end
        join
        check("b_mark", 192'(seen_b), 192'd50);
        check("b_bits", bits_b, {24'h007F00, 24'h081018, 24'h223344, 24'h000000,
                                 24'h000000, 24'h7F7F7F, 24'h7F0001, 24'h000000});
        check("b_timing", 192'(bad_b), 192'd0);

        // Abort at bit 100 with reset, then a clean frame from a cleared buffer.
        brightness0 = 8'd255;
        pulse_start0();
        wait_rises(0, 100, seen_r);
        check("r_mark", 192'(seen_r), 192'd100);
        check("r_line_high", 192'(d0_line), 192'd1);
        rst = 1'b0;
        #1;
        check("r_data_out", 192'(d0_line), 192'd0);
        check("r_busy", 192'(busy0), 192'd0);
        check("r_done", 192'(done0), 192'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        write0(3'd3, 24'h0F0F0F);
        write0(3'd7, 24'hF00001);
        pulse_start0();
        rx_frame(0, 192, 20, 42, 40, 22, 3000, bits_c, bad_c, lead_c);
        check("c_bits", bits_c, {72'h0, 24'h0F0F0F, 72'h0, 24'hF00001});
        check("c_timing", 192'(bad_c), 192'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
